// File: rtl/sample_feeder.sv
// sample_feeder: per-channel input FIFOs that answer resampler pop requests.
//
// Each channel has a circular FIFO of 2**DEPTH_LOG2 x 24-bit samples. Upstream
// samples are tagged with a channel index and written when that channel's
// FIFO is not full. Each cycle pop_i[c] is high returns one sample on slice c
// of data_o, with ack_o[c] high one cycle later. A pop that finds its FIFO
// empty still acks, returns the underrun sample, and sets underrun_o[c].
//
// Build option: SAMPLE_FEEDER_HOLD_EN
//   defined   - the underrun sample repeats the last sample delivered on
//               that channel (0 if none since reset)
//   undefined - the underrun sample is zero
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset (release synchronised here)
//   in_data_i       upstream 24-bit sample
//   in_ch_i         channel tag for in_data_i
//   in_valid_i      upstream sample valid
//   in_ready_o      FIFO selected by in_ch_i is not full (1 for an unused tag)
//   pop_i           per-channel sample request, one per cycle high
//   data_o          channel c on bits [24c+23:24c], held between acks
//   ack_o           per-channel one-cycle strobe qualifying the data_o slice
//   underrun_o      sticky per-channel underrun flag
//   underrun_clr_i  synchronous clear of all underrun_o bits
module sample_feeder #(
  parameter int NUM_CH      = 2,
  parameter int NUM_CH_LOG2 = 1,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [23:0]            in_data_i,
  input  logic [NUM_CH_LOG2-1:0] in_ch_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NUM_CH-1:0]      pop_i,
  output logic [24*NUM_CH-1:0]   data_o,
  output logic [NUM_CH-1:0]      ack_o,
  output logic [NUM_CH-1:0]      underrun_o,
  input  logic                   underrun_clr_i
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  // Reset asserts asynchronously and releases two clock edges later, so
  // every register below leaves reset on the same edge.
  logic r_rst_meta;
  logic r_rst_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic              w_sel_full;

  // A tag with no matching channel leaves w_sel_full at 0, so such samples
  // are accepted and dropped.
  always_comb begin
    w_sel_full = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch_i == NUM_CH_LOG2'(c)) w_sel_full = w_full[c];
    end
  end

  assign in_ready_o = !w_sel_full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [23:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [23:0]   r_data;
    logic          r_ack;
    logic          r_urun;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [23:0]   w_urun_data;

    assign w_full[g]  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                        (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_empty[g] = (r_wptr == r_rptr);

    // Both enables use flags from the start of the cycle: a same-cycle pop
    // does not make room for a write, and a same-cycle write is not bypassed
    // to a pop.
    assign w_wr_en = in_valid_i && (in_ch_i == NUM_CH_LOG2'(g)) && !w_full[g];
    assign w_rd_en = pop_i[g] && !w_empty[g];

`ifdef SAMPLE_FEEDER_HOLD_EN
    // r_data only changes on acks, so it already is the last delivered sample.
    assign w_urun_data = r_data;
`else
    assign w_urun_data = 24'h000000;
`endif

    always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr[PW-2:0]] <= in_data_i;
    end

    always_ff @(posedge clk or negedge r_rst_sync) begin
      if (!r_rst_sync) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_data <= '0;
        r_ack  <= 1'b0;
        r_urun <= 1'b0;
      end else begin
        r_ack <= pop_i[g];
        if (w_wr_en) r_wptr <= r_wptr + PW'(1);
        if (w_rd_en) begin
          r_data <= r_mem[r_rptr[PW-2:0]];
          r_rptr <= r_rptr + PW'(1);
        end else if (pop_i[g]) begin
          r_data <= w_urun_data;
        end
        // A new underrun wins over a coincident clear.
        r_urun <= (pop_i[g] && w_empty[g]) || (r_urun && !underrun_clr_i);
      end
    end

    assign data_o[24*g +: 24] = r_data;
    assign ack_o[g]           = r_ack;
    assign underrun_o[g]      = r_urun;
  end

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [23:0]   in_data_i = '0;
  logic [0:0]    in_ch_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [1:0]    pop_i = '0;
  logic [47:0]   data_o;
  logic [1:0]    ack_o;
  logic [1:0]    underrun_o;
  logic          underrun_clr_i = 1'b0;

  sample_feeder #(.NUM_CH(2), .NUM_CH_LOG2(1), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .in_data_i(in_data_i), .in_ch_i(in_ch_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .pop_i(pop_i),
    .data_o(data_o), .ack_o(ack_o), .underrun_o(underrun_o),
    .underrun_clr_i(underrun_clr_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 0;

  // reference model: buffered samples, last delivered sample, sticky flags
  logic [23:0] mq [NCH][$];
  logic [23:0] last_del [NCH];
  logic [1:0]  exp_urun;
  // scoreboard: expected data and the cycle stamp its ack must appear in
  logic [23:0] sq_d [NCH][$];
  int          sq_c [NCH][$];
  logic [23:0] mon_last [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      sq_d[c].delete();
      sq_c[c].delete();
      last_del[c] = '0;
      mon_last[c] = '0;
    end
    exp_urun = '0;
  endtask

  task automatic step(input logic v, input logic [0:0] ch, input logic [23:0] d,
                      input logic [1:0] p, input logic clr);
    logic        rdy;
    logic [23:0] e;
    logic [1:0]  set;
    @(posedge clk);
    #1;
    chk("underrun", {46'd0, underrun_o}, {46'd0, exp_urun});
    in_valid_i = v; in_ch_i = ch; in_data_i = d; pop_i = p; underrun_clr_i = clr;
    #1;
    rdy = (mq[ch].size() < DEPTH);
    chk("in_ready", {47'd0, in_ready_o}, {47'd0, rdy});
    set = '0;
    for (int c = 0; c < NCH; c++) begin
      if (p[c]) begin
        if (mq[c].size() > 0) begin
          e = mq[c].pop_front();
          last_del[c] = e;
        end else begin
`ifdef SAMPLE_FEEDER_HOLD_EN
          e = last_del[c];
`else
          e = 24'h0;
`endif
          set[c] = 1'b1;
        end
        sq_d[c].push_back(e);
        sq_c[c].push_back(cyc + 1);
      end
    end
    exp_urun = (clr ? 2'b00 : exp_urun) | set;
    if (v && rdy) mq[ch].push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 2'b00, 1'b0);
  endtask

  // asserts reset mid-cycle, right after the ack of the previous pop appears
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    in_valid_i = 1'b0; pop_i = '0; underrun_clr_i = 1'b0;
    #1;
    chk("rst_ack", {46'd0, ack_o}, 48'd0);
    chk("rst_data", data_o, 48'd0);
    chk("rst_urun", {46'd0, underrun_o}, 48'd0);
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (started && rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (ack_o[c]) begin
          if (sq_d[c].size() == 0) begin
            chk("spurious_ack", {47'd0, ack_o[c]}, 48'd0);
          end else begin
            chk("ack_cycle", 48'(sq_c[c][0]), 48'(cyc));
            chk("ack_data", {24'd0, data_o[24*c +: 24]}, {24'd0, sq_d[c][0]});
            mon_last[c] = sq_d[c][0];
            void'(sq_d[c].pop_front());
            void'(sq_c[c].pop_front());
          end
        end else begin
          if (sq_c[c].size() > 0 && sq_c[c][0] <= cyc) begin
            chk("missing_ack", {47'd0, ack_o[c]}, 48'd1);
            void'(sq_d[c].pop_front());
            void'(sq_c[c].pop_front());
          end
          chk("data_hold", {24'd0, data_o[24*c +: 24]}, {24'd0, mon_last[c]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] r;
    flush_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {46'd0, ack_o}, 48'd0);
    chk("reset_data", data_o, 48'd0);
    chk("reset_urun", {46'd0, underrun_o}, 48'd0);
    chk("reset_ready", {47'd0, in_ready_o}, 48'd1);
    started = 1;

    // pop on empty ch0
    step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 24'h0, 2'b00, 1'b1);

    // fill ch0, offer a ninth, then drain back-to-back
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 24'(i), 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    idle(2);

    // interleaved channels, simultaneous pops
    step(1'b1, 1'b0, 24'h10, 2'b00, 1'b0);
    step(1'b1, 1'b1, 24'hA0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 24'h11, 2'b00, 1'b0);
    step(1'b1, 1'b1, 24'hA1, 2'b00, 1'b0);
    step(1'b0, 1'b0, 24'h0, 2'b11, 1'b0);
    step(1'b0, 1'b0, 24'h0, 2'b11, 1'b0);
    idle(2);

    // ch1 at 7 entries: write and pop together, then cross the pointer wrap
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 24'h100 + 24'(i), 2'b00, 1'b0);
    step(1'b1, 1'b1, 24'h55, 2'b10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      r = 24'($urandom);
      step(1'b1, 1'b1, r, 2'b10, 1'b0);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 24'h0, 2'b10, 1'b0);
    idle(2);

    // underrun sample after a delivered value, then clear
    step(1'b1, 1'b0, 24'h123456, 2'b00, 1'b0);
    step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 24'h0, 2'b00, 1'b1);
    idle(2);

    // clear coinciding with a new underrun: set wins
    step(1'b0, 1'b0, 24'h0, 2'b10, 1'b1);
    idle(2);

    // reset mid-burst with 4 entries in ch0
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h200 + 24'(i), 2'b00, 1'b0);
    step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    mid_reset();
    step(1'b0, 1'b0, 24'h0, 2'b01, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = 24'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r,
           2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0));
    end
    idle(3);

    for (int c = 0; c < NCH; c++) chk("drained", 48'(sq_d[c].size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
